// File: rtl/conf_timing_engine.sv
// -----------------------------------------------------------------------------
// conf_timing_engine
//
// Converts CHANNELS BCD unit counts and one shared BCD pulses-per-unit value
// into binary pulse-count timings (units * pulses_per_unit). A single serial
// BCD-to-binary accumulator is shared by all values, and the multiply is a
// serial LSB-first shift-add, so there is one small datapath, not one per
// channel.
//
// Optional build macro: CONF_TIMING_SATURATE_EN
//   defined   : products above 2^TIME_W-1 store all-ones
//   undefined : products are truncated to their low TIME_W bits
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-high reset
//   ce              clock enable; every register holds when ce=0
//   start           conversion request, sampled only in IDLE with ce=1
//   units           CHANNELS BCD values, channel k at [k*DIGITS*4 +: DIGITS*4]
//   pulses_per_unit shared BCD multiplier
//   times           registered timings, channel k at [k*TIME_W +: TIME_W]
//   ready           idle and start not currently asserted
//   busy            conversion in progress
//   done            high while in DONE (one ce-cycle pulse)
//   bcd_err         sticky: a digit > 9 was seen in the current/last conversion
//   dbg_state       current FSM state encoding
//
// Handshake: start is a request qualified by ready; a start seen in IDLE on a
// ce=1 edge is accepted and the inputs are latched on that edge. No back
// pressure exists on the result side; done marks that all channels are stored.
// -----------------------------------------------------------------------------
module conf_timing_engine #(
  parameter int CHANNELS = 4,
  parameter int DIGITS   = 3,
  parameter int OUT_W    = 10,
  parameter int TIME_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic [CHANNELS*DIGITS*4-1:0] units,
  input  logic [DIGITS*4-1:0]          pulses_per_unit,
  output logic [CHANNELS*TIME_W-1:0]   times,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic                         bcd_err,
  output logic [2:0]                   dbg_state
);

  localparam int DW      = DIGITS * 4;
  localparam int PROD_W  = 2 * OUT_W;
  localparam int CNT_MAX = (OUT_W > DIGITS) ? OUT_W : DIGITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV_PPU = 3'd1,
    CONV_CH  = 3'd2,
    MUL      = 3'd3,
    STORE    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state, state_next;

  logic [CHANNELS*DW-1:0] units_lat;
  logic [DW-1:0]          dig_sr;     // digit shift register, MS digit on top
  logic [OUT_W-1:0]       acc;
  logic [OUT_W-1:0]       ppu_bin;
  logic [PROD_W-1:0]      mcand;
  logic [OUT_W-1:0]       mplier;
  logic [PROD_W-1:0]      prod;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;

  logic [3:0]        digit;
  logic              digit_bad;
  logic [3:0]        digit_eff;
  logic [OUT_W-1:0]  acc_next;
  logic              cnt_last;
  logic [PROD_W-1:0] prod_next;
  logic [IDX_W-1:0]  idx_inc;
  logic [DW-1:0]     cur_sel;
  logic [DW-1:0]     next_sel;
  logic [TIME_W-1:0] store_val;

  // Decimal accumulate: acc*10 + d, with illegal digits clamped to 9.
  assign digit     = dig_sr[DW-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  assign digit_eff = digit_bad ? 4'd9 : digit;
  assign acc_next  = (acc << 3) + (acc << 1) + {{(OUT_W-4){1'b0}}, digit_eff};
  assign cnt_last  = (cnt == CNT_W'(1));

  assign prod_next = mplier[0] ? (prod + mcand) : prod;

  assign idx_inc  = idx + IDX_W'(1);
  assign cur_sel  = units_lat[idx*DW +: DW];
  assign next_sel = units_lat[idx_inc*DW +: DW];

`ifdef CONF_TIMING_SATURATE_EN
  localparam logic [PROD_W-1:0] T_MAX = {PROD_W{1'b1}} >> (PROD_W - TIME_W);
  assign store_val = (prod > T_MAX) ? {TIME_W{1'b1}} : prod[TIME_W-1:0];
`else
  assign store_val = prod[TIME_W-1:0];
`endif

  assign ready     = (state == IDLE) && !start;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start)    state_next = CONV_PPU;
      CONV_PPU: if (cnt_last) state_next = CONV_CH;
      CONV_CH:  if (cnt_last) state_next = MUL;
      MUL:      if (cnt_last) state_next = STORE;
      STORE:    state_next = (idx == LAST_IDX) ? DONE : CONV_CH;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      units_lat <= '0;
      dig_sr    <= '0;
      acc       <= '0;
      ppu_bin   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      idx       <= '0;
      times     <= '0;
      bcd_err   <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            units_lat <= units;
            dig_sr    <= pulses_per_unit;
            bcd_err   <= 1'b0;
            idx       <= '0;
            cnt       <= CNT_W'(DIGITS);
            acc       <= '0;
          end
        end
        CONV_PPU: begin
          acc    <= acc_next;
          dig_sr <= dig_sr << 4;
          if (digit_bad) bcd_err <= 1'b1;
          if (cnt_last) begin
            ppu_bin <= acc_next;
            acc     <= '0;
            cnt     <= CNT_W'(DIGITS);
            dig_sr  <= cur_sel;          // idx is 0 here
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        CONV_CH: begin
          acc    <= acc_next;
          dig_sr <= dig_sr << 4;
          if (digit_bad) bcd_err <= 1'b1;
          if (cnt_last) begin
            mcand  <= {{(PROD_W-OUT_W){1'b0}}, acc_next};
            mplier <= ppu_bin;
            prod   <= '0;
            cnt    <= CNT_W'(OUT_W);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (!cnt_last) cnt <= cnt - CNT_W'(1);
        end
        STORE: begin
          times[idx*TIME_W +: TIME_W] <= store_val;
          if (idx != LAST_IDX) begin
            idx    <= idx_inc;
            dig_sr <= next_sel;
            acc    <= '0;
            cnt    <= CNT_W'(DIGITS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_timing_engine.sv
// -----------------------------------------------------------------------------
// Directed bench for conf_timing_engine (default parameters).
// -----------------------------------------------------------------------------
module tb_conf_timing_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        start;
  logic [47:0] units;
  logic [11:0] pulses_per_unit;
  logic [63:0] times;
  logic        ready, busy, done, bcd_err;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  bit ce_toggle = 1'b0;

  conf_timing_engine dut (
    .clk             (clk),
    .rst             (rst),
    .ce              (ce),
    .start           (start),
    .units           (units),
    .pulses_per_unit (pulses_per_unit),
    .times           (times),
    .ready           (ready),
    .busy            (busy),
    .done            (done),
    .bcd_err         (bcd_err),
    .dbg_state       (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (ce_toggle) ce = ~ce;
  endtask

  task automatic start_conv();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tm(input int k);
    logic [63:0] t;
    t = times;
    return {16'd0, t[k*16 +: 16]};
  endfunction

  // Waits for done; n0 is the number of edges already seen since accept.
  task automatic wait_done(input int n0, input int repulse_at,
                           output int lat, output bit ready_seen);
    int n;
    n = n0;
    lat = -1;
    ready_seen = 1'b0;
    while (lat < 0 && n < 1000) begin
      tick();
      n++;
      if (ready) ready_seen = 1'b1;
      if (done) lat = n;
      if (n == repulse_at)     start = 1'b1;
      if (n == repulse_at + 2) start = 1'b0;
    end
  endtask

  int lat;
  bit rdy;
  int done_cnt;

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    start = 1'b0;
    units = '0;
    pulses_per_unit = '0;
    #23;
    check("rst_times", times[31:0] | times[63:32], 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, bcd_err}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    #5 rst = 1'b0;
    tick();

    // basic conversion; inputs change after accept
    units = {12'h002, 12'h007, 12'h003, 12'h001};
    pulses_per_unit = 12'h250;
    start_conv();
    units = 48'h999_999_999_999;
    pulses_per_unit = 12'h999;
    wait_done(0, -10, lat, rdy);
    check("t2_latency", lat, 32'd59);
    check("t2_ready_low", {31'd0, rdy}, 32'd0);
    check("t2_ch0", tm(0), 32'd250);
    check("t2_ch1", tm(1), 32'd750);
    check("t2_ch2", tm(2), 32'd1750);
    check("t2_ch3", tm(3), 32'd500);
    check("t2_err", {31'd0, bcd_err}, 32'd0);
    tick();
    check("t2_idle", {31'd0, busy}, 32'd0);

    // overflow of the 16-bit timing
    units = {12'h999, 12'h007, 12'h003, 12'h001};
    pulses_per_unit = 12'h250;
    start_conv();
    wait_done(0, -10, lat, rdy);
`ifdef CONF_TIMING_SATURATE_EN
    check("t3_ch3_ovf", tm(3), 32'd65535);
`else
    check("t3_ch3_ovf", tm(3), 32'd53142);
`endif
    check("t3_ch2", tm(2), 32'd1750);
    tick();

    // invalid digit in ch1 (A05 -> 905)
    units = {12'h010, 12'h000, 12'hA05, 12'h001};
    pulses_per_unit = 12'h001;
    start_conv();
    repeat (17) tick();
    check("t4_err_before", {31'd0, bcd_err}, 32'd0);
    tick();
    check("t4_err_after", {31'd0, bcd_err}, 32'd1);
    wait_done(18, -10, lat, rdy);
    check("t4_latency", lat, 32'd59);
    check("t4_ch0", tm(0), 32'd1);
    check("t4_ch1", tm(1), 32'd905);
    check("t4_ch2", tm(2), 32'd0);
    check("t4_ch3", tm(3), 32'd10);
    check("t4_err_done", {31'd0, bcd_err}, 32'd1);
    tick();
    check("t4_err_sticky", {31'd0, bcd_err}, 32'd1);
    units = {12'h004, 12'h003, 12'h002, 12'h001};
    pulses_per_unit = 12'h002;
    start_conv();
    check("t4_err_clear", {31'd0, bcd_err}, 32'd0);
    wait_done(0, -10, lat, rdy);
    check("t4b_ch1", tm(1), 32'd4);
    check("t4b_ch3", tm(3), 32'd8);
    tick();

    // ce toggling and ignored re-start
    units = {12'h002, 12'h007, 12'h003, 12'h001};
    pulses_per_unit = 12'h250;
    ce = 1'b1;
    ce_toggle = 1'b1;
    start_conv();
    wait_done(0, 10, lat, rdy);
    check("t5_latency", lat, 32'd118);
    check("t5_ready_low", {31'd0, rdy}, 32'd0);
    check("t5_ch0", tm(0), 32'd250);
    check("t5_ch1", tm(1), 32'd750);
    check("t5_ch2", tm(2), 32'd1750);
    check("t5_ch3", tm(3), 32'd500);
    tick();
    check("t5_done_hold", {31'd0, done}, 32'd1);
    ce_toggle = 1'b0;
    ce = 1'b1;
    tick();
    tick();
    check("t5_idle", {31'd0, busy}, 32'd0);

    // zero multiplier
    pulses_per_unit = 12'h000;
    start_conv();
    wait_done(0, -10, lat, rdy);
    done_cnt = (lat > 0) ? 1 : 0;
    repeat (4) begin
      tick();
      if (done) done_cnt++;
    end
    check("t6_latency", lat, 32'd59);
    check("t6_done_once", done_cnt, 32'd1);
    check("t6_times", times[31:0] | times[63:32], 32'd0);
    check("t6_err", {31'd0, bcd_err}, 32'd0);

    // asynchronous reset during ch2 multiply
    units = {12'h002, 12'h007, 12'h003, 12'h00B};
    pulses_per_unit = 12'h250;
    start_conv();
    repeat (38) tick();
    check("t1_pre_busy", {31'd0, busy}, 32'd1);
    check("t1_pre_err", {31'd0, bcd_err}, 32'd1);
    check("t1_pre_ch0", tm(0), 32'd2250);
    check("t1_pre_ch1", tm(1), 32'd750);
    #3 rst = 1'b1;
    #1;
    check("t1_times", times[31:0] | times[63:32], 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd0);
    check("t1_err", {31'd0, bcd_err}, 32'd0);
    check("t1_ready", {31'd0, ready}, 32'd1);
    #3 rst = 1'b0;
    tick();
    check("t1_post_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conf_timing_engine.md
Name: conf_timing_engine

Overview:
Parametrised successor to the BCD unit-to-pulse timing converter. Converts CHANNELS BCD unit counts plus one shared BCD pulses-per-unit value into binary pulse-count timings (units × pulses_per_unit). It uses one shared serial BCD-to-binary datapath and a serial shift-add multiplier instead of per-channel converters and combinational multipliers. It sits between the configuration/keypad logic and the Morse transmitter/receiver timing counters.

Parameters:
CHANNELS, 4, number of unit-count channels (ch0 = dit, ch1 = dah, ch2 = word, ch3 = tolerance in the default build).
DIGITS, 3, BCD digits per input value.
OUT_W, 10, binary width of a converted BCD value; must hold 10^DIGITS-1.
TIME_W, 16, width of each output timing; TIME_W <= 2*OUT_W.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
ce  in  1  clock enable; all state advances only when ce=1.
start  in  1  request conversion; sampled only in IDLE with ce=1.
units  in  CHANNELS*DIGITS*4  BCD unit counts; channel k is slice [k*DIGITS*4 +: DIGITS*4], MS digit on top.
pulses_per_unit  in  DIGITS*4  BCD multiplier shared by all channels.
times  out  CHANNELS*TIME_W  registered timings; channel k is slice [k*TIME_W +: TIME_W].
ready  out  1  idle and able to accept start.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when all channels have been written.
bcd_err  out  1  sticky flag: an invalid BCD digit (>9) was seen in the last conversion.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (asynchronous, any time, including mid-conversion):
  - state=IDLE; times=0, done=0, busy=0, bcd_err=0.
  - All internal accumulators, counters and input latches cleared.
- ready = (state==IDLE) && !start, combinational. busy = (state!=IDLE).
- ce=0 freezes every register; done holds its value while frozen.
- FSM states: IDLE, CONV_PPU, CONV_CH, MUL, STORE, DONE.
- IDLE: on start && ce:
  - latch units and pulses_per_unit;
  - clear bcd_err; channel index=0; digit counter=DIGITS; acc=0;
  - go to CONV_PPU.
  - start in any other state is ignored; no queuing.
- CONV_PPU:
  - each ce cycle: acc = acc*10 + top digit (computed as (acc<<3)+(acc<<1)+d); shift latch left by 4.
  - after DIGITS cycles, ppu_bin=acc; go to CONV_CH.
- CONV_CH: same digit loop on channel[idx], DIGITS cycles, giving ch_bin; go to MUL.
- MUL: serial shift-add, LSB-first over ppu_bin, OUT_W cycles.
  - product width 2*OUT_W; each cycle: if multiplier LSB=1, add the shifted multiplicand.
- STORE (1 cycle): write times[idx] from the product, resized to TIME_W (see Optional Feature).
  - if idx==CHANNELS-1, go to DONE;
  - else idx++ and go to CONV_CH.
- DONE (1 cycle): done=1, then return to IDLE.
- Latency:
  - done is high in the cycle following DIGITS + CHANNELS*(DIGITS+OUT_W+1) ce-cycles after the start-accept edge.
  - Default: 3 + 4*14 = 59.
  - Channel k is updated exactly at its own STORE edge; channels not yet stored keep their previous values.
- Invalid digit (>9): substitute 9 in the accumulate step and set bcd_err. bcd_err stays set until the next accepted start or rst.
- Zero inputs: a units or pulses_per_unit value of 000 produces timing 0. This is legal and raises no error.
- Inputs may change freely after the start-accept edge; only the latched copies are used.

Optional Feature:
Macro: CONF_TIMING_SATURATE_EN.
- Defined: if the 2*OUT_W product exceeds 2^TIME_W-1, times[k] = all-ones (2^TIME_W-1).
- Undefined: times[k] = product[TIME_W-1:0] (silent truncation).
- When TIME_W == 2*OUT_W the two builds behave identically.

Test Plan:
1. rst pulsed mid-MUL of ch2, asynchronously between edges -> immediately times=0, busy=0, done=0, bcd_err=0, ready=1 (start low).
2. ce=1, units ch0..ch3 = 001, 003, 007, 002, ppu=250, start 1 cycle -> times = 250, 750, 1750, 500; done high exactly 59 cycles after the accept edge; ready low throughout.
3. ch3=999, ppu=250 -> 249750 overflows 16 bits -> times[3]=65535 with CONF_TIMING_SATURATE_EN defined, 53142 without.
4. ch1 digits 0xA,0x0,0x5 -> treated as 905, bcd_err=1 after that digit; a following clean conversion clears bcd_err on accept.
5. start re-pulsed during CONV_CH; ce toggled 1/0 every cycle -> second start ignored; latency doubles to 118 clk cycles; results identical to scenario 2.
6. ppu=000 with nonzero units -> all times=0, done pulse once, bcd_err=0.
